// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the FLL configuration-port sequencer.
// States, response error codes and the FLL register map live here.
package fll_cfg_pkg;

  typedef enum logic [2:0] {
    FLL_ST_IDLE      = 3'd0,
    FLL_ST_REQ       = 3'd1,
    FLL_ST_REL       = 3'd2,
    FLL_ST_LOCK_WAIT = 3'd3,
    FLL_ST_RESP      = 3'd4
  } fll_state_e;

  localparam logic [1:0] FLL_ERR_OK      = 2'd0;
  localparam logic [1:0] FLL_ERR_ACK_TO  = 2'd1;
  localparam logic [1:0] FLL_ERR_LOCK_TO = 2'd2;

  localparam logic [1:0] FLL_ADDR_STATUS = 2'd0;
  localparam logic [1:0] FLL_ADDR_CFG1   = 2'd1;
  localparam logic [1:0] FLL_ADDR_CFG2   = 2'd2;
  localparam logic [1:0] FLL_ADDR_INTEG  = 2'd3;

  // Command as latched at accept; it drives the FLL bus until the next accept.
  typedef struct packed {
    logic        wrn;
    logic [1:0]  add;
    logic [31:0] data;
    logic        wait_lock;
  } fll_cmd_t;

endpackage

// File: rtl/fll_cfg_if.sv
// Register-side command/response channel of the FLL configuration sequencer.
// master = peripheral register block, slave = fll_cfg_ctrl.
interface fll_cfg_if;

  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_wrn_i;
  logic [1:0]  cmd_add_i;
  logic [31:0] cmd_wdata_i;
  logic        cmd_wait_lock_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_err_o;

  modport master (
    output cmd_valid_i, cmd_wrn_i, cmd_add_i, cmd_wdata_i, cmd_wait_lock_i, rsp_ready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  cmd_valid_i, cmd_wrn_i, cmd_add_i, cmd_wdata_i, cmd_wait_lock_i, rsp_ready_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface

// File: rtl/fll_cfg_sync.sv
// Plain flop-chain synchronizer for a single asynchronous level signal.
// Synchronous active-high reset clears every stage.
module fll_cfg_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/fll_cfg_ctrl.sv
// Sequences single register read/write commands onto the FLL four-phase
// req/ack configuration port, with ack/lock timeouts and a held response.
module fll_cfg_ctrl
  import fll_cfg_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT  = 255,
  parameter int unsigned LOCK_TIMEOUT = 4095,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  fll_cfg_if.slave    cfg,
  output logic        busy_o,
  output logic        fll_req_o,
  output logic        fll_wrn_o,
  output logic [1:0]  fll_add_o,
  output logic [31:0] fll_data_o,
  input  logic        fll_ack_i,
  input  logic [31:0] fll_rdata_i,
  input  logic        fll_lock_i,
  output logic        lock_o
);

  localparam logic [2:0] S_IDLE      = FLL_ST_IDLE;
  localparam logic [2:0] S_REQ       = FLL_ST_REQ;
  localparam logic [2:0] S_REL       = FLL_ST_REL;
  localparam logic [2:0] S_LOCK_WAIT = FLL_ST_LOCK_WAIT;
  localparam logic [2:0] S_RESP      = FLL_ST_RESP;

  localparam logic [7:0]  ACK_LIMIT  = 8'(ACK_TIMEOUT);
  localparam logic [15:0] LOCK_LIMIT = 16'(LOCK_TIMEOUT);

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  fll_cmd_t    cmd_q;
  logic [7:0]  ack_cnt_q;
  logic [15:0] lock_cnt_q;
  logic [7:0]  ack_inc;
  logic [15:0] lock_inc;
  logic        ack_to;
  logic        lock_to;
  logic        accept;

  fll_cfg_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (fll_lock_i),
    .q   (lock_o)
  );

  assign fll_wrn_o  = cmd_q.wrn;
  assign fll_add_o  = cmd_q.add;
  assign fll_data_o = cmd_q.data;

  // Timeouts look one count ahead so a limit of N allows exactly N cycles in a state.
  assign ack_inc  = (ack_cnt_q == 8'hFF) ? ack_cnt_q : ack_cnt_q + 8'd1;
  assign lock_inc = (lock_cnt_q == 16'hFFFF) ? lock_cnt_q : lock_cnt_q + 16'd1;
  assign ack_to   = (ack_inc >= ACK_LIMIT);
  assign lock_to  = (lock_inc >= LOCK_LIMIT);
  assign accept   = (state_q == S_IDLE) && cfg.cmd_valid_i && cfg.cmd_ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_REQ;
      end
      S_REQ: begin
        if (fll_ack_i || ack_to) state_d = S_REL;
      end
      S_REL: begin
        if (!fll_ack_i) begin
          if ((cfg.rsp_err_o == FLL_ERR_OK) && !cmd_q.wrn && cmd_q.wait_lock) begin
            state_d = S_LOCK_WAIT;
          end else begin
            state_d = S_RESP;
          end
        end else if (ack_to) begin
          state_d = S_RESP;
        end
      end
      S_LOCK_WAIT: begin
        if (lock_o || lock_to) state_d = S_RESP;
      end
      S_RESP: begin
        if (cfg.rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered copies derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cmd_q           <= '0;
      ack_cnt_q       <= '0;
      lock_cnt_q      <= '0;
      cfg.cmd_ready_o <= 1'b1;
      cfg.rsp_valid_o <= 1'b0;
      cfg.rsp_rdata_o <= '0;
      cfg.rsp_err_o   <= FLL_ERR_OK;
      busy_o          <= 1'b0;
      fll_req_o       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cfg.cmd_ready_o <= (state_d == S_IDLE);
      cfg.rsp_valid_o <= (state_d == S_RESP);
      busy_o          <= (state_d != S_IDLE);
      fll_req_o       <= (state_d == S_REQ);

      if (state_d != state_q) begin
        ack_cnt_q  <= '0;
        lock_cnt_q <= '0;
      end else begin
        if ((state_q == S_REQ) || (state_q == S_REL)) ack_cnt_q <= ack_inc;
        if (state_q == S_LOCK_WAIT) lock_cnt_q <= lock_inc;
      end

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cmd_q.wrn       <= cfg.cmd_wrn_i;
            cmd_q.add       <= cfg.cmd_add_i;
            cmd_q.data      <= cfg.cmd_wdata_i;
            cmd_q.wait_lock <= cfg.cmd_wait_lock_i;
            cfg.rsp_rdata_o <= '0;
            cfg.rsp_err_o   <= FLL_ERR_OK;
          end
        end
        S_REQ: begin
          if (fll_ack_i) begin
            if (cmd_q.wrn) cfg.rsp_rdata_o <= fll_rdata_i;
          end else if (ack_to) begin
            cfg.rsp_err_o <= FLL_ERR_ACK_TO;
          end
        end
        S_REL: begin
          if (fll_ack_i && ack_to && (cfg.rsp_err_o == FLL_ERR_OK)) begin
            cfg.rsp_err_o <= FLL_ERR_ACK_TO;
          end
        end
        S_LOCK_WAIT: begin
          if (!lock_o && lock_to) cfg.rsp_err_o <= FLL_ERR_LOCK_TO;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// Self-checking bench for fll_cfg_ctrl: directed scenarios plus random
// transactions, scored against a phase-duration model of the protocol.
module tb_fll_cfg_ctrl;
  import fll_cfg_pkg::*;

  localparam int ACK_TO  = 8;
  localparam int LOCK_TO = 32;
  localparam int SYNC    = 2;
  localparam int BUDGET  = 300;

  logic        clk;
  logic        rst;
  logic        busy_o;
  logic        fll_req_o;
  logic        fll_wrn_o;
  logic [1:0]  fll_add_o;
  logic [31:0] fll_data_o;
  logic        fll_ack_i;
  logic [31:0] fll_rdata_i;
  logic        fll_lock_i;
  logic        lock_o;

  int checks = 0;
  int errors = 0;

  fll_cfg_if cfg ();

  fll_cfg_ctrl #(
    .ACK_TIMEOUT  (ACK_TO),
    .LOCK_TIMEOUT (LOCK_TO),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg         (cfg),
    .busy_o      (busy_o),
    .fll_req_o   (fll_req_o),
    .fll_wrn_o   (fll_wrn_o),
    .fll_add_o   (fll_add_o),
    .fll_data_o  (fll_data_o),
    .fll_ack_i   (fll_ack_i),
    .fll_rdata_i (fll_rdata_i),
    .fll_lock_i  (fll_lock_i),
    .lock_o      (lock_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          req_len;
    int          rsp_cyc;
    logic [31:0] rdata;
    logic [1:0]  err;
    bit          acked;
  } exp_t;

  // Cycle numbers count from 1 = first cycle after the accepting edge.
  function automatic exp_t model(input bit wrn, input bit wait_lock, input int ack_dly,
                                 input int rel_dly, input int lock_dly, input logic [31:0] rd);
    exp_t e;
    int rel_len, ack_low, lw_start, seen;
    e.acked   = (ack_dly >= 0) && (ack_dly < ACK_TO);
    e.req_len = e.acked ? ack_dly + 1 : ACK_TO;
    e.err     = e.acked ? FLL_ERR_OK : FLL_ERR_ACK_TO;
    e.rdata   = (e.acked && wrn) ? rd : 32'd0;
    rel_len   = 1;
    if (e.acked) begin
      if (rel_dly < ACK_TO) begin
        rel_len = rel_dly + 1;
      end else begin
        rel_len = ACK_TO;
        e.err   = FLL_ERR_ACK_TO;
      end
    end
    ack_low   = e.req_len + rel_len;
    lw_start  = ack_low + 1;
    e.rsp_cyc = lw_start;
    if (e.err == FLL_ERR_OK && !wrn && wait_lock) begin
      seen = (lock_dly < 0) ? lw_start + LOCK_TO : ack_low + lock_dly + SYNC;
      if (seen < lw_start) seen = lw_start;
      if (seen < lw_start + LOCK_TO) begin
        e.rsp_cyc = seen + 1;
      end else begin
        e.rsp_cyc = lw_start + LOCK_TO;
        e.err     = FLL_ERR_LOCK_TO;
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and plays the FLL and the response consumer cycle by cycle.
  task automatic applyStimulus(input string name, input bit wrn, input logic [1:0] add,
                               input logic [31:0] wdata, input bit wait_lock, input int ack_dly,
                               input int rel_dly, input int lock_dly, input logic [31:0] rd,
                               input int rdy_dly, input bit poke);
    exp_t        e;
    int          cyc, req_cycles, rel_cycles;
    int          req_rise, req_fall, ack_rise, ack_fall, rsp_first;
    bit          done, ready_set, hold_bad, bp_bad, order_ok;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        post_valid, post_ready, post_busy;
    e = model(wrn, wait_lock, ack_dly, rel_dly, lock_dly, rd);
    req_cycles = 0; rel_cycles = 0;
    req_rise = -1; req_fall = -1; ack_rise = -1; ack_fall = -1; rsp_first = -1;
    done = 0; ready_set = 0; hold_bad = 0; bp_bad = 0;
    rsp_rdata = '0; rsp_err = '0;
    post_valid = 1'b1; post_ready = 1'b0; post_busy = 1'b1;
    fll_ack_i = 1'b0;
    fll_lock_i = 1'b0;
    fll_rdata_i = ~rd;
    cfg.rsp_ready_i = 1'b0;
    checkOutput({name, ".cmd_ready"}, 32'(cfg.cmd_ready_o), 32'd1);
    cfg.cmd_valid_i     = 1'b1;
    cfg.cmd_wrn_i       = wrn;
    cfg.cmd_add_i       = add;
    cfg.cmd_wdata_i     = wdata;
    cfg.cmd_wait_lock_i = wait_lock;
    tick();
    cfg.cmd_valid_i = 1'b0;
    cyc = 1;
    while (!done && cyc < BUDGET) begin
      if (ready_set) begin
        done       = 1;
        post_valid = cfg.rsp_valid_o;
        post_ready = cfg.cmd_ready_o;
        post_busy  = busy_o;
      end else begin
        if (fll_req_o) begin
          if (req_rise < 0) req_rise = cyc;
          if (fll_data_o !== wdata || fll_add_o !== add || fll_wrn_o !== wrn ||
              !busy_o || cfg.cmd_ready_o) hold_bad = 1;
        end else if (req_rise >= 0 && req_fall < 0) begin
          req_fall = cyc;
        end
        if (cfg.rsp_valid_o) begin
          if (rsp_first < 0) begin
            rsp_first = cyc;
            rsp_rdata = cfg.rsp_rdata_o;
            rsp_err   = cfg.rsp_err_o;
          end else if (cfg.rsp_rdata_o !== rsp_rdata || cfg.rsp_err_o !== rsp_err) begin
            bp_bad = 1;
          end
          if (cfg.cmd_ready_o || fll_req_o || fll_data_o !== wdata) bp_bad = 1;
        end
        if (fll_req_o && !fll_ack_i) begin
          req_cycles++;
          if (ack_dly >= 0 && req_cycles > ack_dly) begin
            fll_ack_i   = 1'b1;
            fll_rdata_i = rd;
            ack_rise    = cyc;
          end
        end else if (!fll_req_o && fll_ack_i) begin
          rel_cycles++;
          if (rel_cycles > rel_dly) begin
            fll_ack_i = 1'b0;
            ack_fall  = cyc;
          end
        end
        if (lock_dly >= 0 && ack_fall >= 0 && cyc == ack_fall + lock_dly) fll_lock_i = 1'b1;
        if (rsp_first >= 0) begin
          if (cyc >= rsp_first + rdy_dly) begin
            cfg.rsp_ready_i = 1'b1;
            cfg.cmd_valid_i = 1'b0;
            ready_set       = 1;
          end else if (poke) begin
            cfg.cmd_valid_i = 1'b1;
            cfg.cmd_wdata_i = ~wdata;
            cfg.cmd_add_i   = ~add;
          end
        end
        tick();
        cyc++;
      end
    end
    cfg.rsp_ready_i = 1'b0;
    checkOutput({name, ".finished"}, 32'(done), 32'd1);
    checkOutput({name, ".rsp_cycle"}, 32'(rsp_first), 32'(e.rsp_cyc));
    checkOutput({name, ".rdata"}, rsp_rdata, e.rdata);
    checkOutput({name, ".err"}, 32'(rsp_err), 32'(e.err));
    checkOutput({name, ".req_rise"}, 32'(req_rise), 32'd1);
    checkOutput({name, ".req_fall"}, 32'(req_fall), 32'(e.req_len + 1));
    checkOutput({name, ".bus_hold"}, 32'(hold_bad), 32'd0);
    checkOutput({name, ".rsp_hold"}, 32'(bp_bad), 32'd0);
    checkOutput({name, ".post_valid"}, 32'(post_valid), 32'd0);
    checkOutput({name, ".post_ready"}, 32'(post_ready), 32'd1);
    checkOutput({name, ".post_busy"}, 32'(post_busy), 32'd0);
    if (e.acked && e.err != FLL_ERR_ACK_TO) begin
      order_ok = (req_rise >= 0) && (ack_rise >= req_rise) && (req_fall > ack_rise) &&
                 (ack_fall >= req_fall) && (rsp_first > ack_fall);
      checkOutput({name, ".four_phase"}, 32'(order_ok), 32'd1);
    end
  endtask

  initial begin
    int ack_dly, rel_dly, lock_dly, rdy_dly;
    rst = 1'b1;
    fll_ack_i = 1'b0;
    fll_rdata_i = '0;
    fll_lock_i = 1'b0;
    cfg.cmd_valid_i = 1'b0;
    cfg.cmd_wrn_i = 1'b0;
    cfg.cmd_add_i = '0;
    cfg.cmd_wdata_i = '0;
    cfg.cmd_wait_lock_i = 1'b0;
    cfg.rsp_ready_i = 1'b0;
    repeat (3) tick();
    checkOutput("reset.cmd_ready", 32'(cfg.cmd_ready_o), 32'd1);
    checkOutput("reset.rsp_valid", 32'(cfg.rsp_valid_o), 32'd0);
    checkOutput("reset.busy", 32'(busy_o), 32'd0);
    checkOutput("reset.req", 32'(fll_req_o), 32'd0);
    checkOutput("reset.fll_data", fll_data_o, 32'd0);
    checkOutput("reset.rsp_err", 32'(cfg.rsp_err_o), 32'd0);
    checkOutput("reset.lock", 32'(lock_o), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] directed transactions");
    applyStimulus("write", 1'b0, FLL_ADDR_CFG1, 32'hA5A5_0001, 1'b0, 3, 0, -1, 32'h0, 0, 1'b0);
    applyStimulus("read", 1'b1, FLL_ADDR_STATUS, 32'h0, 1'b0, 0, 2, -1, 32'h0000_1234, 0, 1'b0);
    applyStimulus("ack_to", 1'b0, FLL_ADDR_CFG2, 32'h1111_2222, 1'b0, -1, 0, -1, 32'h0, 0, 1'b0);
    applyStimulus("after_to", 1'b1, FLL_ADDR_INTEG, 32'h0, 1'b0, 1, 0, -1, 32'hCAFE_0003, 0, 1'b0);
    applyStimulus("ack_edge", 1'b1, FLL_ADDR_CFG1, 32'h0, 1'b0, ACK_TO - 1, 0, -1, 32'h0BAD_F00D, 0, 1'b0);
    applyStimulus("rel_to", 1'b1, FLL_ADDR_CFG2, 32'h0, 1'b0, 1, ACK_TO, -1, 32'h7777_8888, 0, 1'b0);
    applyStimulus("lock_wait", 1'b0, FLL_ADDR_CFG1, 32'h0000_00F0, 1'b1, 1, 0, 20, 32'h0, 0, 1'b0);
    applyStimulus("lock_to", 1'b0, FLL_ADDR_CFG1, 32'h0000_00F1, 1'b1, 1, 0, -1, 32'h0, 0, 1'b0);
    applyStimulus("backpress", 1'b1, FLL_ADDR_CFG2, 32'h5555_AAAA, 1'b0, 2, 1, -1, 32'h1357_9BDF, 10, 1'b1);
    applyStimulus("back2back", 1'b0, FLL_ADDR_INTEG, 32'h0F0F_F0F0, 1'b0, 0, 0, -1, 32'h0, 0, 1'b0);

    $display("[TB] random transactions");
    for (int i = 0; i < 30; i++) begin
      ack_dly  = int'($urandom_range(0, 10));
      if ($urandom_range(0, 7) == 0) ack_dly = -1;
      rel_dly  = int'($urandom_range(0, 9));
      lock_dly = int'($urandom_range(0, 36));
      if ($urandom_range(0, 5) == 0) lock_dly = -1;
      rdy_dly  = int'($urandom_range(0, 3));
      applyStimulus("rand", 1'($urandom), 2'($urandom), $urandom, 1'($urandom),
                    ack_dly, rel_dly, lock_dly, $urandom, rdy_dly, 1'($urandom));
    end

    $display("[TB] reset during request phase");
    fll_ack_i = 1'b0;
    fll_lock_i = 1'b1;
    cfg.cmd_valid_i = 1'b1;
    cfg.cmd_wrn_i = 1'b0;
    cfg.cmd_add_i = FLL_ADDR_CFG2;
    cfg.cmd_wdata_i = 32'hDEAD_BEEF;
    cfg.cmd_wait_lock_i = 1'b0;
    tick();
    cfg.cmd_valid_i = 1'b0;
    repeat (3) tick();
    checkOutput("rst_mid.req_before", 32'(fll_req_o), 32'd1);
    checkOutput("rst_mid.lock_before", 32'(lock_o), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("rst_mid.req", 32'(fll_req_o), 32'd0);
    checkOutput("rst_mid.rsp_valid", 32'(cfg.rsp_valid_o), 32'd0);
    checkOutput("rst_mid.cmd_ready", 32'(cfg.cmd_ready_o), 32'd1);
    checkOutput("rst_mid.lock", 32'(lock_o), 32'd0);
    rst = 1'b0;
    fll_lock_i = 1'b0;
    tick();
    applyStimulus("recover", 1'b1, FLL_ADDR_STATUS, 32'h0, 1'b0, 1, 1, -1, 32'h0000_4321, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
